// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage
// ----------------------------------------------------------------------------
// Instruction-fetch stage and IF/ID pipeline register.
//
// The stage keeps at most one instruction-memory request outstanding. It
// accepts branch or jump redirects from EX and stall or flush from the hazard
// unit. A one-entry skid buffer holds a response that arrives while decode is
// stalled, so the word never has to be fetched again.
//
// Ports
//   clk             in   1   single clock, rising edge
//   rstn            in   1   asynchronous, active-low reset
//   imem_req        out  1   fetch request valid
//   imem_addr       out  32  fetch address (= pcF), word aligned
//   imem_gnt        in   1   request accepted this cycle
//   imem_rvalid     in   1   read data valid, >= 1 cycle after gnt
//   imem_rdata      in   32  instruction word
//   redirect_valid  in   1   taken branch/jump from EX
//   redirect_pc     in   32  redirect target (bits [1:0] ignored)
//   stall           in   1   hold IF/ID contents
//   flush           in   1   replace IF/ID contents with a bubble
//   instrD          out  32  instruction to decode
//   pcD             out  32  PC of instrD
//   validD          out  1   instrD holds a real instruction
//
// Optional build macro IF_PERF_CNT_EN adds these performance counters:
//   fetch_cnt       out  32  accepted requests (imem_req & imem_gnt), wrapping
//   drop_cnt        out  32  discarded responses (drop set), wrapping
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic        validD
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pc_f;
    logic [31:0] pc_inflight;
    logic        drop;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    // ------------------------------------------------------------------
    // Handshake and data-movement qualifiers
    // ------------------------------------------------------------------
    logic        accept;      // request handshake this cycle
    logic        resp;        // response arrives while one is expected
    logic        resp_keep;   // response is for the current program path
    logic        load_resp;   // response goes straight into IF/ID
    logic        buf_write;   // response parks in the skid buffer
    logic        load_buf;    // skid buffer drains into IF/ID
    logic        deliver;     // IF/ID receives a real instruction
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;

    assign accept    = (state == S_REQ) && imem_gnt;
    assign resp      = (state == S_WAIT) && imem_rvalid;
    // A redirect in the same cycle as the response makes that response
    // stale, exactly as if drop had already been set.
    assign resp_keep = resp && !drop && !redirect_valid;
    assign load_resp = resp_keep && !stall;
    assign buf_write = resp_keep && stall;
    assign load_buf  = (state == S_HOLD) && !stall && !redirect_valid;
    assign deliver   = load_resp || load_buf;

    assign deliver_instr = (state == S_HOLD) ? buf_instr : imem_rdata;
    assign deliver_pc    = (state == S_HOLD) ? buf_pc    : pc_inflight;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments, so all
    // registers sample the pre-edge values no matter how processes order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_REQ;
        else       state <= state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_next gets a default before the case statement. This
    // keeps the block combinational on every path, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_REQ: begin
                if (accept) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (resp) state_next = buf_write ? S_HOLD : S_REQ;
            end
            S_HOLD: begin
                if (redirect_valid || !stall) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_req = (state == S_REQ);
    end

    assign imem_addr = pc_f;

    // ------------------------------------------------------------------
    // Fetch PC, in-flight PC and the drop flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_f        <= RESET_PC;
            pc_inflight <= 32'h0;
            drop        <= 1'b0;
        end else begin
            if (redirect_valid) pc_f <= {redirect_pc[31:2], 2'b00};
            else if (accept)    pc_f <= pc_f + 32'd4;   // wraps silently

            if (accept) pc_inflight <= pc_f;

            // A redirect that arrives while a request is in flight marks
            // that response for discard. This includes a redirect in the
            // grant cycle itself.
            if (accept && redirect_valid) begin
                drop <= 1'b1;
            end else if (state == S_WAIT) begin
                if (resp)                drop <= 1'b0;
                else if (redirect_valid) drop <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer. Its contents count only in S_HOLD. A redirect leaves
    // S_HOLD, and that is what clears the buffer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_instr <= NOP_INSTR;
            buf_pc    <= 32'h0;
        end else if (buf_write) begin
            buf_instr <= imem_rdata;
            buf_pc    <= pc_inflight;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register. Priority: redirect > flush > stall > load > bubble.
    // A plain bubble keeps pcD, so decode still sees the last PC.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instrD <= NOP_INSTR;
            pcD    <= 32'h0;
            validD <= 1'b0;
        end else if (redirect_valid || flush) begin
            instrD <= NOP_INSTR;
            pcD    <= 32'h0;
            validD <= 1'b0;
        end else if (stall) begin
            instrD <= instrD;
            pcD    <= pcD;
            validD <= validD;
        end else if (deliver) begin
            instrD <= deliver_instr;
            pcD    <= deliver_pc;
            validD <= 1'b1;
        end else begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (wrapping)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_cnt <= 32'h0;
            drop_cnt  <= 32'h0;
        end else begin
            if (imem_req && imem_gnt) fetch_cnt <= fetch_cnt + 32'd1;
            if (resp && drop)         drop_cnt  <= drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// tb_if_fetch_stage
// ----------------------------------------------------------------------------
// Directed testbench for if_fetch_stage.
//
// A small memory responder grants every request in the cycle it is made.
// It returns pc ^ 32'hA5A5_0000 a programmable number of cycles after the
// grant. Inputs change and outputs are sampled on the falling edge.
// ============================================================================
module tb_if_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        flush;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        validD;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .flush          (flush),
        .instrD         (instrD),
        .pcD            (pcD),
        .validD         (validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Memory responder. It runs on the falling edge and sets up the
    // grant/response inputs for the next rising edge.
    // ------------------------------------------------------------------
    int          cyc      = 0;
    int          lat      = 1;
    int          due      = 0;
    logic        pend     = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          n_req8   = 0;

    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        imem_rvalid = 1'b0;
        if (!rstn) begin
            pend     = 1'b0;
            imem_gnt = 1'b0;
        end else begin
            if (pend && cyc == due) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_addr ^ SALT;
                pend        = 1'b0;
            end
            imem_gnt = imem_req;
            if (imem_req) begin
                pend      = 1'b1;
                pend_addr = imem_addr;
                due       = cyc + lat;
                if (imem_addr == 32'h8) n_req8 = n_req8 + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_tests = n_tests + 1;
        assert (observed === expected)
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Safety net: the directed sequence below is a fixed length.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rstn           = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        step(); step();
        check("rst_req",   {31'h0, imem_req}, 32'h1);
        check("rst_addr",  imem_addr,         32'h0);
        check("rst_valid", {31'h0, validD},   32'h0);
        check("rst_instr", instrD,            NOP);
        check("rst_pcD",   pcD,               32'h0);
        #2 rstn = 1'b1;

        // T2: 0-wait stream, a valid instruction every second cycle
        step();                                          // N1
        check("t2_n1_valid", {31'h0, validD}, 32'h0);
        step();                                          // N2
        check("t2_n2_valid", {31'h0, validD},   32'h0);
        check("t2_n2_req",   {31'h0, imem_req}, 32'h0);
        step();                                          // N3
        check("t2_valid0", {31'h0, validD}, 32'h1);
        check("t2_pc0",    pcD,             32'h0);
        check("t2_instr0", instrD,          32'hA5A5_0000);
        step();                                          // N4
        check("t2_gap",    {31'h0, validD}, 32'h0);
        step();                                          // N5
        check("t2_valid4", {31'h0, validD}, 32'h1);
        check("t2_pc4",    pcD,             32'h4);
        check("t2_instr4", instrD,          32'hA5A5_0004);

        // T3: stall from the rvalid cycle of pc=0x8, held for 3 cycles
        step();                                          // N6
        stall = 1'b1;
        step();                                          // N7
        check("t3_hold1_pc",  pcD,               32'h4);
        check("t3_hold1_val", {31'h0, validD},   32'h0);
        check("t3_hold1_req", {31'h0, imem_req}, 32'h0);
        step();                                          // N8
        check("t3_hold2_pc",  pcD,               32'h4);
        check("t3_hold2_req", {31'h0, imem_req}, 32'h0);
        step();                                          // N9
        check("t3_hold3_pc",  pcD,             32'h4);
        check("t3_hold3_val", {31'h0, validD}, 32'h0);
        stall = 1'b0;
        lat   = 2;                                       // no grant at N9
        step();                                          // N10
        check("t3_valid8", {31'h0, validD}, 32'h1);
        check("t3_pc8",    pcD,             32'h8);
        check("t3_instr8", instrD,          32'hA5A5_0008);
        check("t3_next",   imem_addr,       32'hC);

        // T4: redirect in S_WAIT, 2-cycle latency, late data discarded
        step();                                          // N11
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        step();                                          // N12
        redirect_valid = 1'b0;
        check("t3_one_req8",  n_req8,            32'h1);
        check("t4_wait_req",  {31'h0, imem_req}, 32'h0);
        check("t4_redir_val", {31'h0, validD},   32'h0);
        check("t4_redir_ins", instrD,            NOP);
        step();                                          // N13
        check("t4_addr",  imem_addr,         32'h100);
        check("t4_req",   {31'h0, imem_req}, 32'h1);
        check("t4_drop",  {31'h0, validD},   32'h0);
        step();                                          // N14
        lat = 1;                                         // no grant at N14
        check("t4_wait1", {31'h0, validD}, 32'h0);
        step();                                          // N15
        check("t4_wait2", {31'h0, validD}, 32'h0);
        step();                                          // N16
        check("t4_valid",  {31'h0, validD}, 32'h1);
        check("t4_pc",     pcD,             32'h100);
        check("t4_instr",  instrD,          32'hA5A5_0100);

        // T5: redirect in the same cycle as the grant of 0x104
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();                                          // N17
        redirect_valid = 1'b0;
        check("t5_val",  {31'h0, validD}, 32'h0);
        step();                                          // N18
        check("t5_addr", imem_addr,         32'h200);
        check("t5_req",  {31'h0, imem_req}, 32'h1);
        check("t5_drop", {31'h0, validD},   32'h0);
        step();                                          // N19
        check("t5_gap",  {31'h0, validD}, 32'h0);
        step();                                          // N20
        check("t5_valid", {31'h0, validD}, 32'h1);
        check("t5_pc",    pcD,             32'h200);
        check("t5_instr", instrD,          32'hA5A5_0200);

        // T6: flush and stall together while validD=1
        flush = 1'b1;
        stall = 1'b1;
        step();                                          // N21
        flush = 1'b0;
        stall = 1'b0;
        check("t6_valid", {31'h0, validD}, 32'h0);
        check("t6_instr", instrD,          NOP);
        step();                                          // N22
        check("t6_pcF",   imem_addr,       32'h208);
        check("t6_fetch", pcD,             32'h204);
        check("t6_fval",  {31'h0, validD}, 32'h1);

        // T1: reset asserted mid-run
        #2 rstn = 1'b0;
        #1;
        check("t1_async_addr", imem_addr,       32'h0);
        check("t1_async_val",  {31'h0, validD}, 32'h0);
        step();                                          // N23
        check("t1_addr",  imem_addr,         32'h0);
        check("t1_req",   {31'h0, imem_req}, 32'h1);
        check("t1_valid", {31'h0, validD},   32'h0);
        check("t1_instr", instrD,            NOP);
        #2 rstn = 1'b1;
        step(); step(); step();                          // N24..N26
        check("t1_restart_val", {31'h0, validD}, 32'h1);
        check("t1_restart_pc",  pcD,             32'h0);

        // PC wrap: redirect to the last word, then the next fetch is 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();                                          // N27
        redirect_valid = 1'b0;
        step(); step(); step();                          // N28..N30
        check("wrap_pc",    pcD,             32'hFFFF_FFFC);
        check("wrap_valid", {31'h0, validD}, 32'h1);
        check("wrap_instr", instrD,          32'h5A5A_FFFC);
        check("wrap_next",  imem_addr,       32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
